wrr_arbiter: RTL and testbench

- Weighted round-robin arbiter that shares one downstream resource between N requesters.
- Each requester holds a registered one-hot grant for up to its programmed weight in consecutive cycles.
- The grant then rotates to the next active requester with zero-bubble handover.
- It sits directly between the request sources and the shared resource, replacing plain single-cycle round-robin where bandwidth shares must be unequal.

---
 rtl/wrr_arbiter.sv | 107 ++++++++++
 tb/tb_wrr_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: one registered one-hot grant held for up to
// each requester's weight, rotating with zero-bubble handover.
module wrr_arbiter #(
  parameter int N  = 4,
  parameter int WW = 4,
  parameter int IW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_id,
  output logic            grant_last
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    r_state;
  logic [IW-1:0] r_ptr;
  logic [WW-1:0] r_cnt;
  logic [N-1:0]  r_grant;
  logic [IW-1:0] r_grantId;
  logic          r_grantValid;

  logic          w_release;
  logic [IW-1:0] w_nextPtr;
  logic [IW-1:0] w_searchBase;
  logic          w_found;
  logic [IW-1:0] w_winner;
  logic [WW-1:0] w_winWeight;
  logic [WW-1:0] w_loadCnt;
  logic [N-1:0]  w_winOneHot;

  // On release the search already starts past the outgoing owner, so the
  // handover and the pointer advance happen on the same edge.
  assign w_release    = (r_state == BUSY) && (!req[r_grantId] || (r_cnt == WW'(1)));
  assign w_nextPtr    = (r_grantId == IW'(N-1)) ? '0 : r_grantId + 1'b1;
  assign w_searchBase = w_release ? w_nextPtr : r_ptr;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && req[(int'(w_searchBase) + k) % N]) begin
        w_found  = 1'b1;
        w_winner = IW'((int'(w_searchBase) + k) % N);
      end
    end
  end

  // A zero weight still earns a single cycle of service.
  assign w_winWeight = weight[int'(w_winner)*WW +: WW];
  assign w_loadCnt   = (w_winWeight == '0) ? WW'(1) : w_winWeight;
  assign w_winOneHot = N'(1) << w_winner;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_grant      <= '0;
      r_grantId    <= '0;
      r_grantValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant      <= w_winOneHot;
            r_grantId    <= w_winner;
            r_grantValid <= 1'b1;
            r_cnt        <= w_loadCnt;
            r_state      <= BUSY;
          end
        end
        BUSY: begin
          if (w_release) begin
            r_ptr <= w_nextPtr;
            if (w_found) begin
              r_grant      <= w_winOneHot;
              r_grantId    <= w_winner;
              r_grantValid <= 1'b1;
              r_cnt        <= w_loadCnt;
            end else begin
              r_grant      <= '0;
              r_grantId    <= '0;
              r_grantValid <= 1'b0;
              r_cnt        <= '0;
              r_state      <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grantValid;
  assign grant_id    = r_grantId;
  assign grant_last  = (r_state == BUSY) && (r_cnt == WW'(1));

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed scoreboard bench for wrr_arbiter: each step queues the outputs
// expected after the next edge and checks them one cycle later.
module tb_wrr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] weight;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        grant_last;

  typedef struct {
    string      tag;
    logic [3:0] grant;
    logic [1:0] id;
    logic       valid;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   testCount = 0;
  int   failCount = 0;

  wrr_arbiter #(.N(4), .WW(4), .IW(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .weight      (weight),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .grant_last  (grant_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pushExpected(input string tag, input logic [3:0] g,
                              input logic [1:0] id, input logic last);
    exp_t e;
    e.tag   = tag;
    e.grant = g;
    e.id    = id;
    e.valid = (g != 4'b0000);
    e.last  = last;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    e = sb.pop_front();
    testCount++;
    assert (grant === e.grant) else begin
      failCount++;
      $error("[TB] FAIL %s grant observed=%b expected=%b", e.tag, grant, e.grant);
    end
    testCount++;
    assert (grant_id === e.id) else begin
      failCount++;
      $error("[TB] FAIL %s grant_id observed=%0d expected=%0d", e.tag, grant_id, e.id);
    end
    testCount++;
    assert (grant_valid === e.valid) else begin
      failCount++;
      $error("[TB] FAIL %s grant_valid observed=%b expected=%b", e.tag, grant_valid, e.valid);
    end
    testCount++;
    assert (grant_last === e.last) else begin
      failCount++;
      $error("[TB] FAIL %s grant_last observed=%b expected=%b", e.tag, grant_last, e.last);
    end
    testCount++;
    assert ((grant & (grant - 4'd1)) === 4'b0000) else begin
      failCount++;
      $error("[TB] FAIL %s onehot observed=%b expected=onehot0", e.tag, grant);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] w,
                               input logic [3:0] g, input logic [1:0] id,
                               input logic last, input string tag);
    req    = r;
    weight = w;
    pushExpected(tag, g, id, last);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    req = 4'b0000;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst    = 1'b0;
    req    = 4'b0000;
    weight = 16'h0000;
    #2;
    pushExpected("reset_async", 4'b0000, 2'd0, 1'b0);
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Equal weights, all requesting: one cycle each in strict rotation.
    applyStimulus(4'b1111, 16'h1111, 4'b0001, 2'd0, 1'b1, "fair_0");
    applyStimulus(4'b1111, 16'h1111, 4'b0010, 2'd1, 1'b1, "fair_1");
    applyStimulus(4'b1111, 16'h1111, 4'b0100, 2'd2, 1'b1, "fair_2");
    applyStimulus(4'b1111, 16'h1111, 4'b1000, 2'd3, 1'b1, "fair_3");
    applyStimulus(4'b1111, 16'h1111, 4'b0001, 2'd0, 1'b1, "fair_wrap");

    // Weight 3 versus weight 1.
    doReset();
    applyStimulus(4'b0011, 16'h0013, 4'b0001, 2'd0, 1'b0, "wt_a0");
    applyStimulus(4'b0011, 16'h0013, 4'b0001, 2'd0, 1'b0, "wt_a1");
    applyStimulus(4'b0011, 16'h0013, 4'b0001, 2'd0, 1'b1, "wt_a2");
    applyStimulus(4'b0011, 16'h0013, 4'b0010, 2'd1, 1'b1, "wt_b0");
    applyStimulus(4'b0011, 16'h0013, 4'b0001, 2'd0, 1'b0, "wt_a_again");

    // Sole requester 3 with weight 2 is re-granted without a gap.
    doReset();
    applyStimulus(4'b1000, 16'h2000, 4'b1000, 2'd3, 1'b0, "sole_0");
    applyStimulus(4'b1000, 16'h2000, 4'b1000, 2'd3, 1'b1, "sole_1");
    applyStimulus(4'b1000, 16'h2000, 4'b1000, 2'd3, 1'b0, "sole_2");
    applyStimulus(4'b1000, 16'h2000, 4'b1000, 2'd3, 1'b1, "sole_3");
    applyStimulus(4'b1000, 16'h2000, 4'b1000, 2'd3, 1'b0, "sole_4");

    // Early release hands over to requester 1 on the very next edge.
    doReset();
    applyStimulus(4'b0100, 16'h0500, 4'b0100, 2'd2, 1'b0, "early_0");
    applyStimulus(4'b0100, 16'h0500, 4'b0100, 2'd2, 1'b0, "early_1");
    applyStimulus(4'b0010, 16'h0500, 4'b0010, 2'd1, 1'b1, "early_hand");
    applyStimulus(4'b0010, 16'h0500, 4'b0010, 2'd1, 1'b1, "early_regrant");

    // Zero weight gives one cycle; weight edits only matter at the next grant.
    doReset();
    applyStimulus(4'b0010, 16'h0000, 4'b0010, 2'd1, 1'b1, "w0_first");
    applyStimulus(4'b0010, 16'h0040, 4'b0010, 2'd1, 1'b0, "w4_c4");
    applyStimulus(4'b0010, 16'h0000, 4'b0010, 2'd1, 1'b0, "w4_c3");
    applyStimulus(4'b0010, 16'h0000, 4'b0010, 2'd1, 1'b0, "w4_c2");
    applyStimulus(4'b0010, 16'h0000, 4'b0010, 2'd1, 1'b1, "w4_c1");
    applyStimulus(4'b0010, 16'h0000, 4'b0010, 2'd1, 1'b1, "w0_again");

    // Asynchronous reset mid-grant, restart from index 0, then go idle.
    doReset();
    applyStimulus(4'b0100, 16'h0500, 4'b0100, 2'd2, 1'b0, "mid_grant");
    rst = 1'b0;
    #1;
    pushExpected("mid_reset", 4'b0000, 2'd0, 1'b0);
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(4'b1111, 16'h1111, 4'b0001, 2'd0, 1'b1, "post_reset");
    applyStimulus(4'b0000, 16'h1111, 4'b0000, 2'd0, 1'b0, "to_idle");
    applyStimulus(4'b0000, 16'h1111, 4'b0000, 2'd0, 1'b0, "stay_idle");

    testCount++;
    assert (sb.size() == 0) else begin
      failCount++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
